i2c_master_arbiter: RTL and testbench

- Shares one I2C_Master between two independent sensor FSM clients (e.g. a temperature-sensor FSM and a second sensor FSM).
- Each client requests the bus with Req/Grant. While granted, a client drives the master's control and FIFO signals transparently.
- The block arbitrates round-robin, keeps a grant until the transaction completes, and enforces a busy-timeout watchdog so a hung transfer cannot lock the bus.

---
 rtl/i2c_master_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
// Lets two independent sensor FSM clients share one I2C_Master.
// Clients request the bus with a Req/Grant handshake, and grants alternate
// round-robin. While a client holds the grant, its control and FIFO signals
// pass straight through to the master. A grant is kept until that client's
// transaction completes. A busy-timeout watchdog stops a hung transfer from
// holding the bus forever.
//
// Ports
//   Clk_i, Reset_i          : clock (rising edge); synchronous active-high reset
//   TimeoutCycles_i         : maximum number of consecutive busy cycles per grant; 0 disables the watchdog
//   Req0_i / Req1_i         : bus requests from client 0 / client 1
//   Grant0_o / Grant1_o     : registered grants
//   Timeout_o               : single-cycle pulse when the watchdog fires
//   C0_* / C1_* inputs      : per-client master controls (direction, count, start, FIFO pop/push, data)
//   C0_Busy_o / C1_Busy_o   : each client's view of master busy (forced to 1 when not granted)
//   C0_Error_o / C1_Error_o : each client's view of master error (forced to 0 when not granted)
//   C_Data_o                : read data broadcast to both clients
//   I2C_* outputs / inputs  : connection to the shared I2C_Master
module i2c_master_arbiter #(
    parameter int TimeoutWidth = 16
) (
    input  logic                    Clk_i,
    input  logic                    Reset_i,
    input  logic [TimeoutWidth-1:0] TimeoutCycles_i,
    input  logic                    Req0_i,
    input  logic                    Req1_i,
    output logic                    Grant0_o,
    output logic                    Grant1_o,
    output logic                    Timeout_o,
    input  logic                    C0_ReceiveSend_n_i,
    input  logic                    C1_ReceiveSend_n_i,
    input  logic [7:0]              C0_ReadCount_i,
    input  logic [7:0]              C1_ReadCount_i,
    input  logic                    C0_StartProcess_i,
    input  logic                    C1_StartProcess_i,
    input  logic                    C0_FIFOReadNext_i,
    input  logic                    C1_FIFOReadNext_i,
    input  logic                    C0_FIFOWrite_i,
    input  logic                    C1_FIFOWrite_i,
    input  logic [7:0]              C0_Data_i,
    input  logic [7:0]              C1_Data_i,
    output logic                    C0_Busy_o,
    output logic                    C1_Busy_o,
    output logic                    C0_Error_o,
    output logic                    C1_Error_o,
    output logic [7:0]              C_Data_o,
    output logic                    I2C_ReceiveSend_n_o,
    output logic [7:0]              I2C_ReadCount_o,
    output logic                    I2C_StartProcess_o,
    output logic                    I2C_FIFOReadNext_o,
    output logic                    I2C_FIFOWrite_o,
    output logic [7:0]              I2C_Data_o,
    input  logic                    I2C_Busy_i,
    input  logic                    I2C_Error_i,
    input  logic [7:0]              I2C_Data_i
);

    typedef enum logic [1:0] {
        stIdle,
        stGrant0,
        stGrant1,
        stRelease
    } state_t;

    state_t                  state, state_next;
    logic                    last_grant, last_grant_next;
    logic [TimeoutWidth-1:0] wd_count, wd_count_next, wd_incr;
    logic                    granted, wd_fire;
    logic                    grant0_q, grant1_q;

    // The watchdog compares the busy-run length *including* the current
    // busy cycle against the limit, so with a limit of N it fires on the
    // N-th consecutive busy cycle. The increment saturates so a disabled
    // watchdog cannot wrap around during very long transfers.
    always_comb begin
        granted   = (state == stGrant0) || (state == stGrant1);
        wd_incr   = (wd_count == {TimeoutWidth{1'b1}}) ? wd_count
                                                       : wd_count + TimeoutWidth'(1);
        wd_fire   = granted && I2C_Busy_i && (TimeoutCycles_i != '0)
                    && (wd_incr == TimeoutCycles_i);
        wd_count_next = (granted && I2C_Busy_i && !wd_fire) ? wd_incr : '0;
        Timeout_o = wd_fire;
    end

    // Next-state logic. When both clients request at the same time, the
    // client that did not own the bus last gets the grant. A watchdog fire
    // takes priority over a normal completion. Either exit passes through
    // stRelease so there is a dead cycle between owners.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            stIdle: begin
                if (Req0_i && Req1_i) begin
                    state_next = last_grant ? stGrant0 : stGrant1;
                end else if (Req0_i) begin
                    state_next = stGrant0;
                end else if (Req1_i) begin
                    state_next = stGrant1;
                end
            end
            stGrant0: begin
                if (wd_fire || (!Req0_i && !I2C_Busy_i)) begin
                    state_next      = stRelease;
                    last_grant_next = 1'b0;
                end
            end
            stGrant1: begin
                if (wd_fire || (!Req1_i && !I2C_Busy_i)) begin
                    state_next      = stRelease;
                    last_grant_next = 1'b1;
                end
            end
            stRelease: begin
                state_next = stIdle;
            end
            default: begin
                state_next = stIdle;
            end
        endcase
    end

    // State, round-robin history, watchdog counter and the grant flops.
    // After reset, last_grant is 1 so that client 0 wins the first tie.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state      <= stIdle;
            last_grant <= 1'b1;
            wd_count   <= '0;
            grant0_q   <= 1'b0;
            grant1_q   <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            wd_count   <= wd_count_next;
            grant0_q   <= (state_next == stGrant0);
            grant1_q   <= (state_next == stGrant1);
        end
    end

    assign Grant0_o = grant0_q;
    assign Grant1_o = grant1_q;
    assign C_Data_o = I2C_Data_i;

    // Output steering. Only the owning client reaches the master. Any client
    // that does not hold the grant sees the master as busy and error-free,
    // and whatever it drives is dropped.
    always_comb begin
        I2C_ReceiveSend_n_o = 1'b0;
        I2C_ReadCount_o     = 8'h00;
        I2C_StartProcess_o  = 1'b0;
        I2C_FIFOReadNext_o  = 1'b0;
        I2C_FIFOWrite_o     = 1'b0;
        I2C_Data_o          = 8'h00;
        C0_Busy_o           = 1'b1;
        C1_Busy_o           = 1'b1;
        C0_Error_o          = 1'b0;
        C1_Error_o          = 1'b0;
        case (state)
            stGrant0: begin
                I2C_ReceiveSend_n_o = C0_ReceiveSend_n_i;
                I2C_ReadCount_o     = C0_ReadCount_i;
                I2C_StartProcess_o  = C0_StartProcess_i;
                I2C_FIFOReadNext_o  = C0_FIFOReadNext_i;
                I2C_FIFOWrite_o     = C0_FIFOWrite_i;
                I2C_Data_o          = C0_Data_i;
                C0_Busy_o           = I2C_Busy_i;
                C0_Error_o          = I2C_Error_i | wd_fire;
            end
            stGrant1: begin
                I2C_ReceiveSend_n_o = C1_ReceiveSend_n_i;
                I2C_ReadCount_o     = C1_ReadCount_i;
                I2C_StartProcess_o  = C1_StartProcess_i;
                I2C_FIFOReadNext_o  = C1_FIFOReadNext_i;
                I2C_FIFOWrite_o     = C1_FIFOWrite_i;
                I2C_Data_o          = C1_Data_i;
                C1_Busy_o           = I2C_Busy_i;
                C1_Error_o          = I2C_Error_i | wd_fire;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter
// Self-checking bench for i2c_master_arbiter. The reference model tracks the
// current bus owner, the dead cycle after a release, the last owner and the
// length of the current busy run. Every negative clock edge, all DUT outputs
// are compared against the values the model predicts. Directed scenarios add
// hand-computed literal expectations. A randomized phase follows them.
module tb_i2c_master_arbiter;

    localparam int TW = 16;

    logic          Clk_i = 1'b0;
    logic          Reset_i;
    logic [TW-1:0] TimeoutCycles_i;
    logic          Req0_i, Req1_i;
    logic          Grant0_o, Grant1_o, Timeout_o;
    logic          C0_ReceiveSend_n_i, C1_ReceiveSend_n_i;
    logic [7:0]    C0_ReadCount_i, C1_ReadCount_i;
    logic          C0_StartProcess_i, C1_StartProcess_i;
    logic          C0_FIFOReadNext_i, C1_FIFOReadNext_i;
    logic          C0_FIFOWrite_i, C1_FIFOWrite_i;
    logic [7:0]    C0_Data_i, C1_Data_i;
    logic          C0_Busy_o, C1_Busy_o, C0_Error_o, C1_Error_o;
    logic [7:0]    C_Data_o;
    logic          I2C_ReceiveSend_n_o;
    logic [7:0]    I2C_ReadCount_o;
    logic          I2C_StartProcess_o, I2C_FIFOReadNext_o, I2C_FIFOWrite_o;
    logic [7:0]    I2C_Data_o;
    logic          I2C_Busy_i, I2C_Error_i;
    logic [7:0]    I2C_Data_i;

    int checksTotal  = 0;
    int checksPassed = 0;

    // Reference model state: owner is -1 when no client holds the bus.
    int mOwner    = -1;
    bit mGap      = 1'b0;
    int mLast     = 1;
    int mRun      = 0;
    bit modelValid = 1'b0;

    always #5 Clk_i = ~Clk_i;

    i2c_master_arbiter #(.TimeoutWidth(TW)) dut (
        .Clk_i(Clk_i), .Reset_i(Reset_i), .TimeoutCycles_i(TimeoutCycles_i),
        .Req0_i(Req0_i), .Req1_i(Req1_i),
        .Grant0_o(Grant0_o), .Grant1_o(Grant1_o), .Timeout_o(Timeout_o),
        .C0_ReceiveSend_n_i(C0_ReceiveSend_n_i), .C1_ReceiveSend_n_i(C1_ReceiveSend_n_i),
        .C0_ReadCount_i(C0_ReadCount_i), .C1_ReadCount_i(C1_ReadCount_i),
        .C0_StartProcess_i(C0_StartProcess_i), .C1_StartProcess_i(C1_StartProcess_i),
        .C0_FIFOReadNext_i(C0_FIFOReadNext_i), .C1_FIFOReadNext_i(C1_FIFOReadNext_i),
        .C0_FIFOWrite_i(C0_FIFOWrite_i), .C1_FIFOWrite_i(C1_FIFOWrite_i),
        .C0_Data_i(C0_Data_i), .C1_Data_i(C1_Data_i),
        .C0_Busy_o(C0_Busy_o), .C1_Busy_o(C1_Busy_o),
        .C0_Error_o(C0_Error_o), .C1_Error_o(C1_Error_o),
        .C_Data_o(C_Data_o),
        .I2C_ReceiveSend_n_o(I2C_ReceiveSend_n_o), .I2C_ReadCount_o(I2C_ReadCount_o),
        .I2C_StartProcess_o(I2C_StartProcess_o), .I2C_FIFOReadNext_o(I2C_FIFOReadNext_o),
        .I2C_FIFOWrite_o(I2C_FIFOWrite_o), .I2C_Data_o(I2C_Data_o),
        .I2C_Busy_i(I2C_Busy_i), .I2C_Error_i(I2C_Error_i), .I2C_Data_i(I2C_Data_i)
    );

    // Compares one value and records the result. Any mismatch prints a
    // single report line.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Moves to the next cycle (just after its rising edge), then drives
    // the requests and master busy for that cycle.
    task automatic applyStimulus(input logic r0, input logic r1, input logic busy);
        @(posedge Clk_i);
        #1;
        Req0_i     = r0;
        Req1_i     = r1;
        I2C_Busy_i = busy;
    endtask

    // The watchdog fires on the cycle where the busy run, counting the
    // current cycle, reaches the programmed limit.
    function automatic bit modelFire();
        return (mOwner >= 0) && I2C_Busy_i && (TimeoutCycles_i != '0)
               && ((mRun + 1) == int'(TimeoutCycles_i));
    endfunction

    // Predicts every DUT output from the model's owner and the inputs of
    // the current cycle.
    function automatic logic [34:0] modelOutputs();
        logic       to;
        logic       rs, st, rn, fw;
        logic [7:0] rc, dt;
        to = modelFire();
        rs = 1'b0; st = 1'b0; rn = 1'b0; fw = 1'b0; rc = 8'h00; dt = 8'h00;
        if (mOwner == 0) begin
            rs = C0_ReceiveSend_n_i; rc = C0_ReadCount_i; st = C0_StartProcess_i;
            rn = C0_FIFOReadNext_i;  fw = C0_FIFOWrite_i; dt = C0_Data_i;
        end else if (mOwner == 1) begin
            rs = C1_ReceiveSend_n_i; rc = C1_ReadCount_i; st = C1_StartProcess_i;
            rn = C1_FIFOReadNext_i;  fw = C1_FIFOWrite_i; dt = C1_Data_i;
        end
        return {mOwner == 0, mOwner == 1, to,
                (mOwner == 0) ? I2C_Busy_i : 1'b1,
                (mOwner == 1) ? I2C_Busy_i : 1'b1,
                (mOwner == 0) ? (I2C_Error_i | to) : 1'b0,
                (mOwner == 1) ? (I2C_Error_i | to) : 1'b0,
                I2C_Data_i, rs, rc, st, rn, fw, dt};
    endfunction

    // Advances the model on each rising edge. Stimulus changes 1 time unit
    // after the edge, so the model sees the same inputs that the DUT sampled.
    always @(posedge Clk_i) begin
        if (Reset_i) begin
            mOwner = -1; mGap = 1'b0; mLast = 1; mRun = 0; modelValid = 1'b1;
        end else if (modelValid) begin
            if (mGap) begin
                mGap = 1'b0;
            end else if (mOwner < 0) begin
                if (Req0_i && Req1_i) mOwner = (mLast == 1) ? 0 : 1;
                else if (Req0_i)      mOwner = 0;
                else if (Req1_i)      mOwner = 1;
                mRun = 0;
            end else begin
                if (modelFire() || (!((mOwner == 0) ? Req0_i : Req1_i) && !I2C_Busy_i)) begin
                    mLast = mOwner; mOwner = -1; mGap = 1'b1; mRun = 0;
                end else begin
                    mRun = I2C_Busy_i ? mRun + 1 : 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model. Outputs
    // are sampled on the falling edge, away from the edge that updates them.
    always @(negedge Clk_i) begin
        if (modelValid) begin
            checkOutput("cycle_outputs",
                64'({Grant0_o, Grant1_o, Timeout_o, C0_Busy_o, C1_Busy_o, C0_Error_o,
                     C1_Error_o, C_Data_o, I2C_ReceiveSend_n_o, I2C_ReadCount_o,
                     I2C_StartProcess_o, I2C_FIFOReadNext_o, I2C_FIFOWrite_o, I2C_Data_o}),
                64'(modelOutputs()));
        end
    end

    task automatic doReset();
        @(posedge Clk_i);
        #1;
        Reset_i = 1'b1; Req0_i = 1'b0; Req1_i = 1'b0; I2C_Busy_i = 1'b0;
        repeat (2) @(posedge Clk_i);
        #1;
        Reset_i = 1'b0;
    endtask

    // Directed scenarios with literal expectations, followed by the
    // randomized soak.
    initial begin
        int n;
        int timeoutSeen;
        Reset_i = 1'b1; TimeoutCycles_i = '0; Req0_i = 1'b0; Req1_i = 1'b0;
        C0_ReceiveSend_n_i = 1'b0; C1_ReceiveSend_n_i = 1'b0;
        C0_ReadCount_i = 8'h00; C1_ReadCount_i = 8'h00;
        C0_StartProcess_i = 1'b0; C1_StartProcess_i = 1'b0;
        C0_FIFOReadNext_i = 1'b0; C1_FIFOReadNext_i = 1'b0;
        C0_FIFOWrite_i = 1'b0; C1_FIFOWrite_i = 1'b0;
        C0_Data_i = 8'h00; C1_Data_i = 8'h00;
        I2C_Busy_i = 1'b0; I2C_Error_i = 1'b0; I2C_Data_i = 8'h00;

        // Reset state, then a single request from client 0
        doReset();
        @(negedge Clk_i);
        checkOutput("reset_grant0", 64'(Grant0_o), 64'd0);
        checkOutput("reset_grant1", 64'(Grant1_o), 64'd0);
        checkOutput("reset_timeout", 64'(Timeout_o), 64'd0);
        checkOutput("reset_c0_busy", 64'(C0_Busy_o), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        C0_StartProcess_i = 1'b1;
        @(negedge Clk_i);
        checkOutput("req_cycle_grant0", 64'(Grant0_o), 64'd0);
        checkOutput("req_cycle_start_blocked", 64'(I2C_StartProcess_o), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge Clk_i);
        checkOutput("grant0_asserted", 64'(Grant0_o), 64'd1);
        checkOutput("start_passthrough", 64'(I2C_StartProcess_o), 64'd1);
        checkOutput("c1_busy_while_g0", 64'(C1_Busy_o), 64'd1);
        C0_StartProcess_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge Clk_i);
        checkOutput("g0_released", 64'(Grant0_o), 64'd0);

        // Simultaneous requests from reset, then the handover to client 1
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge Clk_i);
        checkOutput("tie_grant0_first", 64'(Grant0_o), 64'd1);
        checkOutput("tie_grant1_wait", 64'(Grant1_o), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge Clk_i);
        checkOutput("tie_grant0_fall", 64'(Grant0_o), 64'd0);
        n = 0;
        while (!Grant1_o && n < 10) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            n++;
            @(negedge Clk_i);
        end
        checkOutput("handover_gap_cycles", 64'(n), 64'd2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Client 0 drops its request while the master is still busy
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            @(negedge Clk_i);
            checkOutput("hold_while_busy", 64'(Grant0_o), 64'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge Clk_i);
        checkOutput("hold_busy_fall_cycle", 64'(Grant0_o), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge Clk_i);
        checkOutput("drop_after_busy", 64'(Grant0_o), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Watchdog with a limit of 5: busy stuck while client 1 is granted
        TimeoutCycles_i = 16'd5;
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk_i);
            checkOutput($sformatf("wd_timeout_c%0d", k), 64'(Timeout_o), 64'(k == 5));
            checkOutput($sformatf("wd_c1_error_c%0d", k), 64'(C1_Error_o), 64'(k == 5));
            if (k < 5) applyStimulus(1'b0, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge Clk_i);
        checkOutput("wd_grant1_dropped", 64'(Grant1_o), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Data from the client without the grant must not reach the master;
        // also checks a reset in the middle of a grant
        TimeoutCycles_i = '0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        C1_FIFOWrite_i = 1'b1; C1_Data_i = 8'hAA; C0_Data_i = 8'h55; C0_FIFOWrite_i = 1'b0;
        @(negedge Clk_i);
        checkOutput("ungranted_write_blocked", 64'(I2C_FIFOWrite_o), 64'd0);
        checkOutput("granted_data_only", 64'(I2C_Data_o), 64'h55);
        @(posedge Clk_i);
        #1;
        C0_FIFOWrite_i = 1'b1;
        @(negedge Clk_i);
        checkOutput("granted_write_passes", 64'(I2C_FIFOWrite_o), 64'd1);
        @(posedge Clk_i);
        #1;
        Reset_i = 1'b1;
        @(posedge Clk_i);
        #1;
        Reset_i = 1'b0;
        @(negedge Clk_i);
        checkOutput("midreset_grant0", 64'(Grant0_o), 64'd0);
        checkOutput("midreset_i2c_data", 64'(I2C_Data_o), 64'd0);
        checkOutput("midreset_i2c_write", 64'(I2C_FIFOWrite_o), 64'd0);
        C0_FIFOWrite_i = 1'b0; C1_FIFOWrite_i = 1'b0; C0_Data_i = 8'h00; C1_Data_i = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Watchdog disabled: long busy run, longer than the counter range
        TimeoutCycles_i = '0;
        timeoutSeen = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 70000; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            @(negedge Clk_i);
            if (Timeout_o) timeoutSeen++;
        end
        checkOutput("wd_disabled_no_timeout", 64'(timeoutSeen), 64'd0);
        checkOutput("wd_disabled_grant_held", 64'(Grant0_o), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Randomized soak against the model
        for (int k = 0; k < 4000; k++) begin
            applyStimulus(($urandom_range(0, 5) == 0) ? ~Req0_i : Req0_i,
                          ($urandom_range(0, 5) == 0) ? ~Req1_i : Req1_i,
                          ($urandom_range(0, 3) == 0) ? ~I2C_Busy_i : I2C_Busy_i);
            if ($urandom_range(0, 99) == 0) TimeoutCycles_i = TW'($urandom_range(0, 12));
            I2C_Error_i        = ($urandom_range(0, 7) == 0);
            I2C_Data_i         = 8'($urandom);
            C0_ReceiveSend_n_i = 1'($urandom); C1_ReceiveSend_n_i = 1'($urandom);
            C0_ReadCount_i     = 8'($urandom); C1_ReadCount_i     = 8'($urandom);
            C0_StartProcess_i  = 1'($urandom); C1_StartProcess_i  = 1'($urandom);
            C0_FIFOReadNext_i  = 1'($urandom); C1_FIFOReadNext_i  = 1'($urandom);
            C0_FIFOWrite_i     = 1'($urandom); C1_FIFOWrite_i     = 1'($urandom);
            C0_Data_i          = 8'($urandom); C1_Data_i          = 8'($urandom);
        end

        @(posedge Clk_i);
        @(negedge Clk_i);
        #1;
        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
